// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings for the elevator plant model
package elevator_pkg;

    localparam logic [1:0] AC_UP   = 2'd0;
    localparam logic [1:0] AC_DOWN = 2'd1;
    localparam logic [1:0] AC_STOP = 2'd2;

    typedef enum logic [1:0] {
        DOOR_CLOSED_S  = 2'd0,
        DOOR_OPENING_S = 2'd1,
        DOOR_OPEN_S    = 2'd2,
        DOOR_CLOSING_S = 2'd3
    } door_state_e;

    localparam logic [1:0] FAULT_NONE        = 2'd0;
    localparam logic [1:0] FAULT_OVERTRAVEL  = 2'd1;
    localparam logic [1:0] FAULT_DOOR_MOTION = 2'd2;
    localparam logic [1:0] FAULT_OFF_FLOOR   = 2'd3;

    // Codes 2 and 3 both mean "stop"; only bit 1 matters.
    function automatic logic is_stop(input logic [1:0] ac);
        return ac[1];
    endfunction

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - controller <-> plant signal bundle
interface elevator_if;
    import elevator_pkg::*;

    logic [1:0] AC;
    logic       Open;
    logic       S1;
    logic       S2;
    logic       S3;
    logic       S4;
    logic       DOOR_CLOSED;
    logic       MOVING;
    logic [1:0] FAULT;

    modport master (
        output AC, Open,
        input  S1, S2, S3, S4, DOOR_CLOSED, MOVING, FAULT
    );

    modport slave (
        input  AC, Open,
        output S1, S2, S3, S4, DOOR_CLOSED, MOVING, FAULT
    );

endinterface

// File: rtl/elevator_door.sv
// rtl/elevator_door.sv - door FSM with per-transition timer
module elevator_door
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_open,
    input  logic i_at_floor,
    input  logic i_stop_cmd,
    output logic o_door_closed,
    output logic o_off_floor_req
);

    localparam logic [3:0] TIMER_LAST = 4'(DOOR_CYCLES - 1);

    door_state_e r_state;
    logic [3:0]  r_timer;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= DOOR_CLOSED_S;
            r_timer <= 4'd0;
        end else begin
            case (r_state)
                DOOR_CLOSED_S: begin
                    if (i_open && i_at_floor && i_stop_cmd) begin
                        r_state <= DOOR_OPENING_S;
                        r_timer <= 4'd0;
                    end
                end
                DOOR_OPENING_S: begin
                    if (r_timer == TIMER_LAST) begin
                        r_state <= DOOR_OPEN_S;
                        r_timer <= 4'd0;
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                DOOR_OPEN_S: begin
                    if (!i_open) begin
                        r_state <= DOOR_CLOSING_S;
                        r_timer <= 4'd0;
                    end
                end
                DOOR_CLOSING_S: begin
                    // A renewed request reverses the door with a fresh timer.
                    if (i_open) begin
                        r_state <= DOOR_OPENING_S;
                        r_timer <= 4'd0;
                    end else if (r_timer == TIMER_LAST) begin
                        r_state <= DOOR_CLOSED_S;
                        r_timer <= 4'd0;
                    end else begin
                        r_timer <= r_timer + 4'd1;
                    end
                end
                default: begin
                    r_state <= DOOR_CLOSED_S;
                    r_timer <= 4'd0;
                end
            endcase
        end
    end

    assign o_door_closed   = (r_state == DOOR_CLOSED_S);
    assign o_off_floor_req = (r_state == DOOR_CLOSED_S) && i_open && !i_at_floor;

endmodule

// File: rtl/elevator_plant.sv
// rtl/elevator_plant.sv - four-floor car position, interlock and fault latch
module elevator_plant
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    elevator_if.slave  bus
);

    localparam logic [3:0] OFFSET_LAST = 4'(TRAVEL_CYCLES - 1);

    logic [1:0] r_floor;
    logic [3:0] r_offset;
    logic       r_moving;
    logic [1:0] r_fault;

    logic       w_at_floor;
    logic       w_at_top;
    logic       w_at_bottom;
    logic       w_up_cmd;
    logic       w_down_cmd;
    logic       w_door_closed;
    logic       w_off_floor_req;
    logic       w_move_up;
    logic       w_move_down;
    logic [1:0] w_fault_code;

    assign w_at_floor  = (r_offset == 4'd0);
    assign w_at_top    = w_at_floor && (r_floor == 2'd3);
    assign w_at_bottom = w_at_floor && (r_floor == 2'd0);
    assign w_up_cmd    = (bus.AC == AC_UP);
    assign w_down_cmd  = (bus.AC == AC_DOWN);

    elevator_door #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door (
        .CLK            (CLK),
        .RESET          (RESET),
        .i_open         (bus.Open),
        .i_at_floor     (w_at_floor),
        .i_stop_cmd     (is_stop(bus.AC)),
        .o_door_closed  (w_door_closed),
        .o_off_floor_req(w_off_floor_req)
    );

    assign w_move_up   = w_up_cmd   && w_door_closed && !w_at_top;
    assign w_move_down = w_down_cmd && w_door_closed && !w_at_bottom;

    // Checked in ascending code order so simultaneous faults record the lowest.
    always_comb begin
        w_fault_code = FAULT_NONE;
        if ((w_up_cmd && w_at_top) || (w_down_cmd && w_at_bottom)) begin
            w_fault_code = FAULT_OVERTRAVEL;
        end else if ((w_up_cmd || w_down_cmd) && !w_door_closed) begin
            w_fault_code = FAULT_DOOR_MOTION;
        end else if (w_off_floor_req) begin
            w_fault_code = FAULT_OFF_FLOOR;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_floor  <= 2'd0;
            r_offset <= 4'd0;
            r_moving <= 1'b0;
            r_fault  <= FAULT_NONE;
        end else begin
            r_moving <= w_move_up || w_move_down;
            if (w_move_up) begin
                if (r_offset == OFFSET_LAST) begin
                    r_floor  <= r_floor + 2'd1;
                    r_offset <= 4'd0;
                end else begin
                    r_offset <= r_offset + 4'd1;
                end
            end else if (w_move_down) begin
                if (r_offset == 4'd0) begin
                    r_floor  <= r_floor - 2'd1;
                    r_offset <= OFFSET_LAST;
                end else begin
                    r_offset <= r_offset - 4'd1;
                end
            end
            if (r_fault == FAULT_NONE) begin
                r_fault <= w_fault_code;
            end
        end
    end

    assign bus.S1          = w_at_floor && (r_floor == 2'd0);
    assign bus.S2          = w_at_floor && (r_floor == 2'd1);
    assign bus.S3          = w_at_floor && (r_floor == 2'd2);
    assign bus.S4          = w_at_floor && (r_floor == 2'd3);
    assign bus.DOOR_CLOSED = w_door_closed;
    assign bus.MOVING      = r_moving;
    assign bus.FAULT       = r_fault;

endmodule

// File: tb/tb_elevator_plant.sv
// tb/tb_elevator_plant.sv - directed vector bench for elevator_plant
module tb_elevator_plant;

    typedef struct {
        logic [1:0] ac;
        logic       open;
        logic [3:0] s;
        logic       dc;
        logic       mov;
        logic [1:0] f;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[18];

    always #5 CLK = ~CLK;

    elevator_if bus ();

    elevator_plant #(
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES  (2)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_all(input string name, input logic [3:0] s, input logic dc,
                              input logic mov, input logic [1:0] f);
        check({name, "_sens"}, {4'd0, bus.S4, bus.S3, bus.S2, bus.S1}, {4'd0, s});
        check({name, "_dc"}, {7'd0, bus.DOOR_CLOSED}, {7'd0, dc});
        check({name, "_mov"}, {7'd0, bus.MOVING}, {7'd0, mov});
        check({name, "_fault"}, {6'd0, bus.FAULT}, {6'd0, f});
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(input logic [1:0] ac, input logic open);
        bus.AC   = ac;
        bus.Open = open;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET    = 1'b0;
        bus.AC   = 2'd2;
        bus.Open = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    initial begin
        bus.AC   = 2'd2;
        bus.Open = 1'b0;

        for (int k = 1; k <= 12; k++) begin
            vecs[k-1] = '{2'd0, 1'b0, ((k % 4) == 0) ? (4'b0001 << (k / 4)) : 4'b0000,
                          1'b1, 1'b1, 2'd0};
        end
        vecs[12] = '{2'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd1};
        vecs[13] = '{2'd2, 1'b0, 4'b1000, 1'b1, 1'b0, 2'd1};
        vecs[14] = '{2'd1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[15] = '{2'd1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[16] = '{2'd1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[17] = '{2'd1, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd1};

        do_reset();
        expect_all("reset", 4'b0001, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            step(2'd2, 1'b0);
            expect_all($sformatf("idle%0d", i), 4'b0001, 1'b1, 1'b0, 2'd0);
        end

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].ac, vecs[i].open);
            expect_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].dc, vecs[i].mov, vecs[i].f);
        end

        // Door at floor 2, then motion request while open
        do_reset();
        for (int i = 0; i < 4; i++) step(2'd0, 1'b0);
        expect_all("at_fl2", 4'b0010, 1'b1, 1'b1, 2'd0);
        step(2'd2, 1'b1);
        expect_all("opening0", 4'b0010, 1'b0, 1'b0, 2'd0);
        step(2'd2, 1'b1);
        step(2'd2, 1'b1);
        expect_all("open", 4'b0010, 1'b0, 1'b0, 2'd0);
        step(2'd0, 1'b1);
        expect_all("move_open", 4'b0010, 1'b0, 1'b0, 2'd2);
        step(2'd2, 1'b0);
        expect_all("closing0", 4'b0010, 1'b0, 1'b0, 2'd2);
        step(2'd2, 1'b0);
        expect_all("closing1", 4'b0010, 1'b0, 1'b0, 2'd2);
        step(2'd2, 1'b0);
        expect_all("closed", 4'b0010, 1'b1, 1'b0, 2'd2);

        // Mid-shaft stop, off-floor open request, then reopen during closing
        do_reset();
        for (int i = 0; i < 6; i++) step(2'd0, 1'b0);
        step(2'd2, 1'b0);
        expect_all("midshaft_stop", 4'b0000, 1'b1, 1'b0, 2'd0);
        step(2'd2, 1'b1);
        expect_all("offfloor_open", 4'b0000, 1'b1, 1'b0, 2'd3);
        step(2'd0, 1'b0);
        step(2'd0, 1'b0);
        expect_all("at_fl3", 4'b0100, 1'b1, 1'b1, 2'd3);
        step(2'd2, 1'b1);
        step(2'd2, 1'b1);
        step(2'd2, 1'b1);
        step(2'd2, 1'b0);
        expect_all("closing_a", 4'b0100, 1'b0, 1'b0, 2'd3);
        step(2'd2, 1'b1);
        expect_all("reopen0", 4'b0100, 1'b0, 1'b0, 2'd3);
        step(2'd2, 1'b1);
        expect_all("reopen1", 4'b0100, 1'b0, 1'b0, 2'd3);
        step(2'd2, 1'b1);
        expect_all("reopen2", 4'b0100, 1'b0, 1'b0, 2'd3);
        step(2'd2, 1'b0);
        step(2'd2, 1'b0);
        expect_all("reclose1", 4'b0100, 1'b0, 1'b0, 2'd3);
        step(2'd2, 1'b0);
        expect_all("reclosed", 4'b0100, 1'b1, 1'b0, 2'd3);

        // Simultaneous overtravel and door-open motion records code 1
        do_reset();
        step(2'd2, 1'b1);
        step(2'd2, 1'b1);
        step(2'd2, 1'b1);
        step(2'd1, 1'b1);
        expect_all("simul_fault", 4'b0001, 1'b0, 1'b0, 2'd1);

        // Asynchronous reset mid-travel
        do_reset();
        for (int i = 0; i < 6; i++) step(2'd0, 1'b0);
        step(2'd2, 1'b1);
        expect_all("pre_reset", 4'b0000, 1'b1, 1'b0, 2'd3);
        bus.Open = 1'b0;
        #2 RESET = 1'b0;
        #1 expect_all("async_reset", 4'b0001, 1'b1, 1'b0, 2'd0);
        @(negedge CLK);
        RESET = 1'b1;
        step(2'd2, 1'b0);
        expect_all("post_release", 4'b0001, 1'b1, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_plant.md
ELEVATOR_PLANT -- requirements
Module: elevator_plant

Interface
REQ-001 The module SHALL have parameter TRAVEL_CYCLES, default 4: clock cycles to move between adjacent floors, legal range 2..15.
REQ-002 The module SHALL have parameter DOOR_CYCLES, default 2: clock cycles for each door transition (opening or closing), legal range 1..15.
REQ-003 CLK  input  1  clock; all state SHALL change on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 AC  input  2  motor command from the controller: 0 up, 1 down, 2 stop, 3 treated as stop.
REQ-006 Open  input  1  door-open request from the controller.
REQ-007 S1, S2, S3, S4  output  1 each  floor sensors, at most one high at a time, high only when the car is exactly at that floor.
REQ-008 DOOR_CLOSED  output  1  high when the door FSM is in CLOSED.
REQ-009 MOVING  output  1  high in any cycle where the car position changed on the preceding edge.
REQ-010 FAULT  output  2  sticky fault code: 0 none, 1 overtravel, 2 motion with door not closed, 3 door open request off-floor.

Function
REQ-011 Position SHALL be held as floor index F (0..3) plus offset O (0..TRAVEL_CYCLES-1); the car is at a floor when O==0.
REQ-012 S(F+1) SHALL be high iff O==0; sensors SHALL be decoded from the position registers with no extra delay.
REQ-013 With AC==0, door CLOSED, not at top: O==TRAVEL_CYCLES-1 -> F+1, O=0; else O+1.
REQ-014 With AC==1, door CLOSED, not at bottom: O==0 -> F-1, O=TRAVEL_CYCLES-1; else O-1.
REQ-015 Up from floor 1 (F=0, O=0): S1 SHALL drop after edge 1 and S2 SHALL rise after edge TRAVEL_CYCLES.
REQ-016 AC==2 or 3 SHALL hold position, including mid-shaft (O!=0, all sensors low), with no fault.
REQ-017 AC==0 at F=3,O=0 or AC==1 at F=0,O=0 SHALL hold position and set FAULT=1.
REQ-018 AC==0 or 1 while door not CLOSED SHALL hold position and set FAULT=2.
REQ-019 Door FSM states: CLOSED, OPENING, OPEN, CLOSING.
REQ-020 CLOSED->OPENING when Open==1, O==0, AC in {2,3}; Open==1 with O!=0 SHALL stay CLOSED and set FAULT=3.
REQ-021 OPENING->OPEN after DOOR_CYCLES cycles; OPEN holds while Open==1; OPEN->CLOSING when Open==0.
REQ-022 CLOSING->CLOSED after DOOR_CYCLES cycles; Open==1 during CLOSING SHALL return to OPENING with the door timer restarted.
REQ-023 FAULT SHALL latch the first non-zero code and hold until reset; later faults SHALL not overwrite it; simultaneous faults SHALL record the lowest code.
REQ-024 Behaviour other than FAULT latching SHALL be unaffected by FAULT (plant keeps modelling).
REQ-025 MOVING SHALL be registered: high for exactly the cycles following a position update.

Reset
REQ-026 RESET low SHALL asynchronously force F=0, O=0, door CLOSED, door timer 0, FAULT=0, MOVING=0.
REQ-027 After reset, outputs SHALL be S1=1, S2=S3=S4=0, DOOR_CLOSED=1, MOVING=0, FAULT=0.
REQ-028 Reset asserted mid-travel or mid-door-transition SHALL abandon the operation and return to the reset state; no motion SHALL occur on the first edge after release unless AC commands it.

Structure
REQ-029 Package elevator_pkg SHALL hold AC encodings (AC_UP=0, AC_DOWN=1, AC_STOP=2), the door state enumeration, and FAULT code constants.
REQ-030 The door FSM and its timer SHALL be a sub-module elevator_door (inputs Open, at_floor, stop_cmd; outputs door_closed, off-floor request flag).
REQ-031 Position counter, sensor decode, interlock and fault latch SHALL live in elevator_plant.

Verification
REQ-032 Reset release, AC=2, Open=0 for 10 cycles -> S1=1, DOOR_CLOSED=1, MOVING=0, FAULT=0 throughout.
REQ-033 AC=0 from floor 1, TRAVEL_CYCLES=4, 12 cycles -> S2 high after edge 4, S3 after edge 8, S4 after edge 12, sensors low between.
REQ-034 At floor 4 apply AC=0 -> position held, S4 stays high, FAULT=1; then AC=1 -> car descends, FAULT stays 1.
REQ-035 At floor 2, AC=2, Open=1, DOOR_CYCLES=2 -> DOOR_CLOSED low after edge 1; AC=0 while OPEN -> no motion, FAULT=2.
REQ-036 Stop mid-shaft (O=2), Open=1 -> door stays CLOSED, FAULT=3; Open=1 during CLOSING -> returns to OPENING.
REQ-037 Assert RESET at O=2 between floors 2 and 3 -> immediate S1=1, FAULT=0, DOOR_CLOSED=1.
